// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared delayed-write field positions, FSM states and request type
package cpu_pkg;
  localparam int DELAY_CNT_MSB  = 23;
  localparam int DELAY_CNT_LSB  = 16;
  localparam int DELAY_VAL_MSB  = 15;
  localparam int DELAY_VAL_LSB  = 8;
  localparam int DELAY_ADDR_MSB = 7;
  localparam int DELAY_ADDR_LSB = 0;

  typedef enum logic [1:0] {IDLE, COUNT, FIRE} dly_state_t;

  typedef logic [23:0] delay_req_t;
endpackage

// File: rtl/delay_req_fifo.sv
// rtl/delay_req_fifo.sv - DEPTH-entry request queue with wrap-bit pointers and sync clear
module delay_req_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  delay_req_t  din,
  output delay_req_t  dout,
  output logic        full,
  output logic        empty,
  output logic [PW:0] count
);
  delay_req_t  r_mem [DEPTH];
  logic [PW:0] r_wptr;
  logic [PW:0] r_rptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign count     = r_wptr - r_rptr;
  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign w_do_pop  = pop && !empty;
  // A pop at the same edge frees the slot a push into a full queue needs.
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !clr) r_mem[r_wptr[PW-1:0]] <= din;
  end
endmodule

// File: rtl/delay_write_unit.sv
// rtl/delay_write_unit.sv - queues delayed-write requests, counts each down, then issues the write
module delay_write_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          delay,
  input  logic [23:0]   delay_data,
  input  logic          flush,
  input  logic          wr_ready,
  output logic          wr_en,
  output logic [7:0]    wr_addr,
  output logic [7:0]    wr_data,
  output logic [23:0]   indelay_data,
  output logic [PW:0]   pending,
  output logic          full,
  output logic          overflow
);
  dly_state_t  r_state;
  logic [7:0]  r_cnt;
  logic        r_wr_en;
  logic [7:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_overflow;
  delay_req_t  w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  // Flush wins over both a push and a completing write at the same edge.
  assign w_push = delay && !flush;
  assign w_pop  = (r_state == FIRE) && wr_ready && !flush;

  delay_req_fifo #(.DEPTH(DEPTH), .PW(PW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (w_push),
    .pop   (w_pop),
    .din   (delay_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (flush) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_wr_en <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (!w_empty) begin
            r_state <= COUNT;
            r_cnt   <= w_head[DELAY_CNT_MSB:DELAY_CNT_LSB];
          end
          COUNT: if (r_cnt == '0) begin
            r_state   <= FIRE;
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_head[DELAY_ADDR_MSB:DELAY_ADDR_LSB];
            r_wr_data <= w_head[DELAY_VAL_MSB:DELAY_VAL_LSB];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
          FIRE: if (wr_ready) begin
            r_state <= IDLE;
            r_wr_en <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    indelay_data = '0;
    case (r_state)
      COUNT, FIRE: indelay_data = {r_cnt, w_head[DELAY_VAL_MSB:DELAY_VAL_LSB],
                                   w_head[DELAY_ADDR_MSB:DELAY_ADDR_LSB]};
      IDLE:        if (!w_empty) indelay_data = w_head;
      default:     indelay_data = '0;
    endcase
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign full     = w_full;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_delay_write_unit.sv
// tb/tb_delay_write_unit.sv - table-driven and sequence checks for delay_write_unit
module tb_delay_write_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        delay = 1'b0;
  logic [23:0] delay_data = '0;
  logic        flush = 1'b0;
  logic        wr_ready = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [23:0] indelay_data;
  logic [2:0]  pending;
  logic        full;
  logic        overflow;

  always #5 clk = ~clk;

  delay_write_unit #(.DEPTH(4), .PW(2)) dut (
    .clk(clk), .rst_n(rst_n), .delay(delay), .delay_data(delay_data),
    .flush(flush), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .indelay_data(indelay_data), .pending(pending),
    .full(full), .overflow(overflow)
  );

  typedef struct {
    bit          rst;
    logic        dly;
    logic [23:0] d;
    logic        rdy;
    logic        fl;
    logic        en;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [23:0] ind;
    logic [2:0]  pend;
    logic        full;
    logic        ovf;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input bit rst, input logic dly, input logic [23:0] d, input logic rdy,
                     input logic fl, input logic en, input logic [7:0] addr, input logic [7:0] data,
                     input logic [23:0] ind, input logic [2:0] pend, input logic f, input logic ovf);
    vec_t v;
    v.rst = rst; v.dly = dly; v.d = d; v.rdy = rdy; v.fl = fl; v.en = en;
    v.addr = addr; v.data = data; v.ind = ind; v.pend = pend; v.full = f; v.ovf = ovf;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] act_vec(input logic en_mask);
    return {18'h0, wr_en, en_mask ? wr_addr : 8'h0, en_mask ? wr_data : 8'h0,
            indelay_data, pending, full, overflow};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; delay = 1'b0; flush = 1'b0; wr_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    logic [63:0] exp;
    for (int i = lo; i < hi; i++) begin
      if (tv[i].rst) do_reset();
      delay = tv[i].dly; delay_data = tv[i].d; wr_ready = tv[i].rdy; flush = tv[i].fl;
      step();
      exp = {18'h0, tv[i].en, tv[i].en ? tv[i].addr : 8'h0, tv[i].en ? tv[i].data : 8'h0,
             tv[i].ind, tv[i].pend, tv[i].full, tv[i].ovf};
      check($sformatf("row%0d", i), act_vec(tv[i].en), exp);
    end
    delay = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int end_ab, end_c, end_d, first;
    int cyc[$];
    logic [7:0] ad[$];
    logic [7:0] exp_drain[3];

    // Single N=3 request, then zero-count request.
    add(1,1,24'h035A10,1,0, 0,0,0,24'h035A10,1,0,0);
    add(0,0,24'h0,1,0,      0,0,0,24'h035A10,1,0,0);
    add(0,0,24'h0,1,0,      0,0,0,24'h025A10,1,0,0);
    add(0,0,24'h0,1,0,      0,0,0,24'h015A10,1,0,0);
    add(0,0,24'h0,1,0,      0,0,0,24'h005A10,1,0,0);
    add(0,0,24'h0,1,0,      1,8'h10,8'h5A,24'h005A10,1,0,0);
    add(0,0,24'h0,1,0,      0,0,0,24'h000000,0,0,0);
    add(0,0,24'h0,1,0,      0,0,0,24'h000000,0,0,0);
    add(0,1,24'h00FF01,1,0, 0,0,0,24'h00FF01,1,0,0);
    add(0,0,24'h0,1,0,      0,0,0,24'h00FF01,1,0,0);
    add(0,0,24'h0,1,0,      1,8'h01,8'hFF,24'h00FF01,1,0,0);
    add(0,0,24'h0,1,0,      0,0,0,24'h000000,0,0,0);
    end_ab = tv.size();
    // Fill with wr_ready low, overflow, then push+pop while full.
    add(1,1,24'h00B030,0,0, 0,0,0,24'h00B030,1,0,0);
    add(0,1,24'h00B131,0,0, 0,0,0,24'h00B030,2,0,0);
    add(0,1,24'h00B232,0,0, 1,8'h30,8'hB0,24'h00B030,3,0,0);
    add(0,1,24'h00B333,0,0, 1,8'h30,8'hB0,24'h00B030,4,1,0);
    add(0,1,24'h00B434,0,0, 1,8'h30,8'hB0,24'h00B030,4,1,1);
    add(0,0,24'h0,0,0,      1,8'h30,8'hB0,24'h00B030,4,1,1);
    add(0,1,24'h00B535,1,0, 0,0,0,24'h00B131,4,1,1);
    add(0,0,24'h0,0,0,      0,0,0,24'h00B131,4,1,1);
    add(0,0,24'h0,0,0,      1,8'h31,8'hB1,24'h00B131,4,1,1);
    end_c = tv.size();
    // Flush during COUNT, then flush beating a simultaneous push.
    add(1,1,24'h0A1122,1,0, 0,0,0,24'h0A1122,1,0,0);
    add(0,0,24'h0,1,0,      0,0,0,24'h0A1122,1,0,0);
    add(0,0,24'h0,1,0,      0,0,0,24'h091122,1,0,0);
    add(0,0,24'h0,1,0,      0,0,0,24'h081122,1,0,0);
    add(0,0,24'h0,1,1,      0,0,0,24'h000000,0,0,0);
    add(0,0,24'h0,1,0,      0,0,0,24'h000000,0,0,0);
    add(0,1,24'h05AABB,1,1, 0,0,0,24'h000000,0,0,0);
    add(0,0,24'h0,1,0,      0,0,0,24'h000000,0,0,0);
    end_d = tv.size();

    #2 rst_n = 1'b0;
    #1 check("reset_state", act_vec(1'b1), 64'h0);

    run_rows(0, end_ab);

    // Four back-to-back N=1 requests: writes at edges 3,7,11,15.
    wr_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k < 4) begin
        delay = 1'b1;
        delay_data = {8'h01, 8'(160 + k), 8'(32 + k)};
      end else begin
        delay = 1'b0;
      end
      step();
      if (wr_en) begin
        cyc.push_back(k);
        ad.push_back(wr_addr);
      end
    end
    check("b2b_count", 64'(cyc.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < cyc.size()) begin
        check($sformatf("b2b_addr%0d", i), 64'(ad[i]), 64'(32 + i));
        check($sformatf("b2b_cycle%0d", i), 64'(cyc[i]), 64'(3 + 4 * i));
      end
    end

    run_rows(end_ab, end_c);

    // Drain the remaining queue; overflow must stay set.
    exp_drain[0] = 8'h32; exp_drain[1] = 8'h33; exp_drain[2] = 8'h35;
    ad.delete();
    wr_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (wr_en) ad.push_back(wr_addr);
    end
    check("drain_count", 64'(ad.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < ad.size()) check($sformatf("drain_addr%0d", i), 64'(ad[i]), 64'(exp_drain[i]));
    check("drain_end", {60'h0, pending, overflow}, {60'h0, 3'd0, 1'b1});

    run_rows(end_c, end_d);

    // No write may leak out after the flush.
    first = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (wr_en) first++;
    end
    check("flush_no_write", 64'(first), 64'd0);

    // Async reset while in FIRE abandons the write.
    wr_ready = 1'b0;
    delay = 1'b1; delay_data = 24'h003344;
    step();
    delay = 1'b0;
    step();
    step();
    check("fire_before_reset", {63'h0, wr_en}, 64'd1);
    #3 rst_n = 1'b0;
    #1 check("async_reset_outputs", act_vec(1'b1), 64'h0);
    step();
    rst_n = 1'b1;
    wr_ready = 1'b1;
    first = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (wr_en || indelay_data != 24'h0 || pending != 3'd0) first++;
    end
    check("idle_after_reset", 64'(first), 64'd0);

    // N=2 after reset: wr_en first seen after edge E0'+4.
    delay = 1'b1; delay_data = 24'h025566;
    step();
    delay = 1'b0;
    first = -1;
    for (int k = 1; k < 16; k++) begin
      step();
      if (wr_en && first < 0) begin
        first = k;
        check("post_reset_write", {48'h0, wr_addr, wr_data}, {48'h0, 8'h66, 8'h55});
      end
    end
    check("post_reset_latency", 64'(first), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
